// File: rtl/cv32e40x_lsu_rsp_unit.sv
// LSU response unit: tracks in-flight OBI data transactions, merges split halves,
// aligns/extends load data and queues results for write-back.
module cv32e40x_lsu_rsp_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_size_i,
  input  logic        req_sext_i,
  input  logic [1:0]  req_lsb_i,
  input  logic        req_last_i,
  input  logic        req_we_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        lsu_valid_o,
  input  logic        lsu_ready_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic [2:0]  cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [1:0] size;
    logic       sext;
    logic [1:0] lsb;
    logic       last;
    logic       we;
  } attr_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } res_t;

  attr_t            attr_mem_q [DEPTH];
  attr_t            attr_mem_n [DEPTH];
  logic [PTR_W-1:0] attr_wr_q, attr_wr_n, attr_rd_q, attr_rd_n;
  logic [CNT_W-1:0] attr_cnt_q, attr_cnt_n;

  res_t             res_mem_q [DEPTH];
  res_t             res_mem_n [DEPTH];
  logic [PTR_W-1:0] res_wr_q, res_wr_n, res_rd_q, res_rd_n;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_n;

  logic [CNT_W-1:0] cnt_n;
  logic             ready_n, valid_n;
  res_t             head_n;
  logic [31:0]      lo_q, lo_n;
  logic             err_q, err_n, split_q, split_n;

  logic             req_hs, attr_pop, res_push, res_hs;
  attr_t            head;
  logic [63:0]      wide;
  logic [31:0]      d, ext;
  res_t             new_res;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: attribute FIFO, split staging, result FIFO, credits and output image
  always_comb begin
    attr_mem_n = attr_mem_q;
    attr_wr_n  = attr_wr_q;
    attr_rd_n  = attr_rd_q;
    res_mem_n  = res_mem_q;
    res_wr_n   = res_wr_q;
    res_rd_n   = res_rd_q;
    lo_n       = lo_q;
    err_n      = err_q;
    split_n    = split_q;
    res_push   = 1'b0;

    req_hs   = req_valid_i && req_ready_o;
    attr_pop = obi_rvalid_i && (attr_cnt_q != '0);
    res_hs   = lsu_valid_o && lsu_ready_i;
    head     = attr_mem_q[attr_rd_q];

    if (req_hs) begin
      attr_mem_n[attr_wr_q] = '{size: req_size_i, sext: req_sext_i, lsb: req_lsb_i,
                                last: req_last_i, we: req_we_i};
      attr_wr_n = ptr_inc(attr_wr_q);
    end
    if (attr_pop) begin
      attr_rd_n = ptr_inc(attr_rd_q);
    end
    attr_cnt_n = attr_cnt_q + CNT_W'(req_hs) - CNT_W'(attr_pop);

    // A non-split load sees a zero upper word, so one shift covers both cases
    wide = split_q ? {obi_rdata_i, lo_q} : {32'b0, obi_rdata_i};
    d    = 32'(wide >> {head.lsb, 3'b000});
    case (head.size)
      2'b00:   ext = {{24{head.sext & d[7]}}, d[7:0]};
      2'b01:   ext = {{16{head.sext & d[15]}}, d[15:0]};
      default: ext = d;
    endcase
    if (head.we) begin
      ext = '0;
    end
    new_res = '{err: err_q | obi_err_i, data: ext};

    if (attr_pop) begin
      if (!head.last) begin
        lo_n    = obi_rdata_i;
        err_n   = err_q | obi_err_i;
        split_n = 1'b1;
      end else begin
        res_push = 1'b1;
        err_n    = 1'b0;
        split_n  = 1'b0;
      end
    end

    if (res_push) begin
      res_mem_n[res_wr_q] = new_res;
      res_wr_n = ptr_inc(res_wr_q);
    end
    if (res_hs) begin
      res_rd_n = ptr_inc(res_rd_q);
    end
    res_cnt_n = res_cnt_q + CNT_W'(res_push) - CNT_W'(res_hs);

    cnt_n = cnt_o + CNT_W'(req_hs) - CNT_W'(attr_pop && !head.last) - CNT_W'(res_hs);
    ready_n = cnt_n < DEPTH_C;
    valid_n = res_cnt_n != '0;

    // Freshly pushed entry becomes the head when it lands on the next read slot
    if (res_push && (res_wr_q == res_rd_n)) begin
      head_n = new_res;
    end else begin
      head_n = res_mem_q[res_rd_n];
    end
    if (!valid_n) begin
      head_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attr_mem_q  <= '{default: '0};
      attr_wr_q   <= '0;
      attr_rd_q   <= '0;
      attr_cnt_q  <= '0;
      res_mem_q   <= '{default: '0};
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      res_cnt_q   <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      split_q     <= 1'b0;
      cnt_o       <= '0;
      req_ready_o <= 1'b1;
      lsu_valid_o <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_err_o   <= 1'b0;
    end else begin
      attr_mem_q  <= attr_mem_n;
      attr_wr_q   <= attr_wr_n;
      attr_rd_q   <= attr_rd_n;
      attr_cnt_q  <= attr_cnt_n;
      res_mem_q   <= res_mem_n;
      res_wr_q    <= res_wr_n;
      res_rd_q    <= res_rd_n;
      res_cnt_q   <= res_cnt_n;
      lo_q        <= lo_n;
      err_q       <= err_n;
      split_q     <= split_n;
      cnt_o       <= cnt_n;
      req_ready_o <= ready_n;
      lsu_valid_o <= valid_n;
      lsu_rdata_o <= head_n.data;
      lsu_err_o   <= head_n.err;
    end
  end

  // A response with nothing outstanding is a bus protocol violation
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    obi_rvalid_i |-> (attr_cnt_q != '0));

endmodule

// File: tb/tb_cv32e40x_lsu_rsp_unit.sv
// Bench for cv32e40x_lsu_rsp_unit: directed vector table, hand sequences for
// back-pressure and reset, then randomized traffic against a byte-level model.
module tb_cv32e40x_lsu_rsp_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk, rst_n;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_size_i;
  logic        req_sext_i;
  logic [1:0]  req_lsb_i;
  logic        req_last_i, req_we_i;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;
  logic        lsu_valid_o, lsu_ready_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic [2:0]  cnt_o;

  cv32e40x_lsu_rsp_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_size_i(req_size_i), .req_sext_i(req_sext_i), .req_lsb_i(req_lsb_i),
    .req_last_i(req_last_i), .req_we_i(req_we_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  lsb;
    logic        last;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } res_t;

  typedef struct {
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  lsb;
    logic        we;
    logic        split;
    logic [31:0] rd0;
    logic        er0;
    logic [31:0] rd1;
    logic        er1;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  txn_t pend_q[$];
  txn_t out_q[$];
  res_t exp_q[$];
  logic        m_split;
  logic [31:0] m_lo;
  logic        m_err;
  int p_req, p_rsp, p_rdy;
  int checks, errors, n_results;
  res_t last_obs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: pick bytes out of the little-endian byte image of the access
  function automatic logic [31:0] ref_data(input txn_t t, input logic split, input logic [31:0] lo);
    logic [7:0] b [8];
    longint v;
    int n;
    for (int i = 0; i < 4; i++) begin
      b[i]   = split ? lo[8*i +: 8] : t.rdata[8*i +: 8];
      b[i+4] = split ? t.rdata[8*i +: 8] : 8'h00;
    end
    n = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(b[int'(t.lsb) + i]) << (8 * i);
    if (t.sext && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    if (t.we) return 32'h0;
    return v[31:0];
  endfunction

  task automatic add_instr(input logic [1:0] size, input logic sext, input logic [1:0] lsb,
                           input logic we, input logic split, input logic [31:0] rd0,
                           input logic er0, input logic [31:0] rd1, input logic er1);
    if (split) pend_q.push_back('{size, sext, lsb, 1'b0, we, rd0, er0});
    pend_q.push_back('{size, sext, lsb, 1'b1, we, rd1, er1});
  endtask

  // One cycle, entered and left at a negedge: check, drive, account, advance
  task automatic step();
    txn_t t;
    int unsigned held;
    held = out_q.size() + exp_q.size();
    chk("cnt", 32'(cnt_o), held);
    chk("ready", 32'(req_ready_o), 32'(held < DEPTH));
    chk("valid", 32'(lsu_valid_o), 32'(exp_q.size() != 0));

    req_valid_i = (pend_q.size() != 0) && ($urandom_range(99) < p_req);
    if (pend_q.size() != 0) begin
      t = pend_q[0];
      req_size_i = t.size; req_sext_i = t.sext; req_lsb_i = t.lsb;
      req_last_i = t.last; req_we_i = t.we;
    end
    obi_rvalid_i = (out_q.size() != 0) && ($urandom_range(99) < p_rsp);
    obi_rdata_i  = obi_rvalid_i ? out_q[0].rdata : $urandom;
    obi_err_i    = obi_rvalid_i ? out_q[0].err : 1'b0;
    lsu_ready_i  = $urandom_range(99) < p_rdy;

    if (lsu_valid_o && lsu_ready_i && exp_q.size() != 0) begin
      chk("rdata", lsu_rdata_o, exp_q[0].data);
      chk("err", 32'(lsu_err_o), 32'(exp_q[0].err));
      last_obs = '{lsu_rdata_o, lsu_err_o};
      n_results++;
      void'(exp_q.pop_front());
    end
    if (obi_rvalid_i) begin
      t = out_q.pop_front();
      if (!t.last) begin
        m_split = 1'b1; m_lo = t.rdata; m_err = m_err | t.err;
      end else begin
        exp_q.push_back('{ref_data(t, m_split, m_lo), m_err | t.err});
        m_split = 1'b0; m_err = 1'b0;
      end
    end
    if (req_valid_i && req_ready_o) out_q.push_back(pend_q.pop_front());
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid_i = 0; req_size_i = 0; req_sext_i = 0; req_lsb_i = 0;
    req_last_i = 0; req_we_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0;
    obi_err_i = 0; lsu_ready_i = 0;
  endtask

  vec_t vecs [12];

  initial begin
    int start, k;
    logic [1:0] sz, lsb;
    int n;
    checks = 0; errors = 0; n_results = 0;
    m_split = 0; m_lo = 0; m_err = 0;
    clear_inputs();
    rst_n = 1'b0;

    vecs[0]  = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80112233, 1'b0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{2'd0, 1'b0, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80112233, 1'b0, 32'h00000080, 1'b0};
    vecs[3]  = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80011234, 1'b0, 32'hFFFF8001, 1'b0};
    vecs[4]  = '{2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1234F00D, 1'b0, 32'h0000F00D, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00007F00, 1'b0, 32'h0000007F, 1'b0};
    vecs[6]  = '{2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
    vecs[7]  = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
    vecs[8]  = '{2'd2, 1'b0, 2'd1, 1'b0, 1'b1, 32'h44332211, 1'b0, 32'h88776655, 1'b0, 32'h55443322, 1'b0};
    vecs[9]  = '{2'd1, 1'b1, 2'd3, 1'b0, 1'b1, 32'hAB000000, 1'b1, 32'h000000CD, 1'b0, 32'hFFFFCDAB, 1'b1};
    vecs[10] = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 2'd2, 1'b0, 1'b1, 32'h44332211, 1'b0, 32'h88776655, 1'b0, 32'h66554433, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(lsu_valid_o), 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, full-throughput handshakes
    p_req = 100; p_rsp = 100; p_rdy = 100;
    for (int i = 0; i < 12; i++) begin
      add_instr(vecs[i].size, vecs[i].sext, vecs[i].lsb, vecs[i].we, vecs[i].split,
                vecs[i].rd0, vecs[i].er0, vecs[i].rd1, vecs[i].er1);
      start = n_results; k = 0;
      while (n_results == start && k < 30) begin step(); k++; end
      chk($sformatf("vec%0d_done", i), 32'(n_results - start), 32'd1);
      chk($sformatf("vec%0d_data", i), last_obs.data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(last_obs.err), 32'(vecs[i].exp_err));
    end

    // Back-pressure: two results held while WB stalls
    p_rdy = 0;
    add_instr(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hA5A50001, 1'b0);
    add_instr(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h5A5A0002, 1'b0);
    k = 0;
    while ((pend_q.size() != 0 || out_q.size() != 0) && k < 20) begin step(); k++; end
    step();
    chk("bp_ready", 32'(req_ready_o), 32'd0);
    chk("bp_cnt", 32'(cnt_o), 32'd2);
    chk("bp_valid", 32'(lsu_valid_o), 32'd1);
    chk("bp_head0", lsu_rdata_o, 32'hA5A50001);
    p_rdy = 100;
    step();
    chk("bp_ready_back", 32'(req_ready_o), 32'd1);
    chk("bp_head1", lsu_rdata_o, 32'h5A5A0002);
    step();
    chk("bp_empty", 32'(lsu_valid_o), 32'd0);
    chk("bp_cnt0", 32'(cnt_o), 32'd0);

    // Reset with one result queued and one transaction outstanding
    p_rdy = 0; p_rsp = 0;
    add_instr(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h01020304, 1'b0);
    add_instr(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h05060708, 1'b0);
    step();
    p_rsp = 100;
    step();
    p_rsp = 0;
    step();
    chk("pre_rst_cnt", 32'(cnt_o), 32'd2);
    chk("pre_rst_valid", 32'(lsu_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(lsu_valid_o), 32'd0);
    chk("async_rst_cnt", 32'(cnt_o), 32'd0);
    chk("async_rst_ready", 32'(req_ready_o), 32'd1);
    chk("async_rst_rdata", lsu_rdata_o, 32'd0);
    clear_inputs();
    pend_q.delete(); out_q.delete(); exp_q.delete();
    m_split = 0; m_lo = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    p_req = 75; p_rsp = 60; p_rdy = 70;
    for (int c = 0; c < 3000; c++) begin
      if (pend_q.size() < 2) begin
        sz  = 2'($urandom_range(2));
        lsb = 2'($urandom_range(3));
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        add_instr(sz, 1'($urandom), lsb, ($urandom_range(3) == 0), (int'(lsb) + n > 4),
                  $urandom, ($urandom_range(7) == 0), $urandom, ($urandom_range(7) == 0));
      end
      step();
    end
    p_req = 100; p_rsp = 100; p_rdy = 100;
    k = 0;
    while ((pend_q.size() != 0 || out_q.size() != 0 || exp_q.size() != 0) && k < 100) begin
      step(); k++;
    end
    chk("drain_left", pend_q.size() + out_q.size() + exp_q.size(), 32'd0);
    chk("drain_cnt", 32'(cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
